// File: rtl/layer_buf_pkg.sv
// Shared constants and types for the layer-1 to layer-2 ping-pong activation buffer.
// Build option: LAYER_RESULT_BUFFER_BINARIZE_EN (see layer_result_buffer.sv).
package layer_buf_pkg;

    localparam int WIDTH_DEF = 256;
    localparam int LANE_DEF  = 16;
    localparam int DEPTH_DEF = 7;
    localparam int LANES     = WIDTH_DEF / LANE_DEF;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } bank_state_e;

    typedef logic [WIDTH_DEF-1:0] act_vec_t;

    function automatic int lanes_of(input int width, input int lane);
        return width / lane;
    endfunction

endpackage

// File: rtl/lrb_bank.sv
// One frame of activation vectors: registered write port, combinational read port.
// Contents survive reset and flush; only the occupancy flags are cleared.
module lrb_bank #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/layer_result_buffer.sv
// Ping-pong activation store between layer 1 and layer 2 (two DEPTH-vector banks).
// Define LAYER_RESULT_BUFFER_BINARIZE_EN to store each lane as all-ones/all-zeros by its MSB.
module layer_result_buffer
    import layer_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANE  = LANE_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH)-1:0] rd_index,
    output logic                     rd_last,
    output logic [1:0]               bank_full
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NLANES = lanes_of(WIDTH, LANE);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH-1:0] wdata_st;
    logic [WIDTH-1:0] bank_rdata [2];

    // All outputs come from registers only; no input-to-output paths.
    assign wr_ready  = (state_q[wr_bank_q] == FILLING);
    assign rd_valid  = (state_q[rd_bank_q] == FULL);
    assign rd_data   = rd_valid ? bank_rdata[rd_bank_q] : '0;
    assign rd_index  = rd_ptr_q;
    assign rd_last   = rd_valid && (rd_ptr_q == LAST);
    assign bank_full = {state_q[1] == FULL, state_q[0] == FULL};

    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_valid && rd_ready;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
`ifdef LAYER_RESULT_BUFFER_BINARIZE_EN
        assign wdata_st[i*LANE +: LANE] = {LANE{wr_data[i*LANE + LANE - 1]}};
`else
        assign wdata_st[i*LANE +: LANE] = wr_data[i*LANE +: LANE];
`endif
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic we;

        assign we = rst_n && !flush && wr_fire && (wr_bank_q == 1'(b));

        lrb_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk   (clk),
            .we    (we),
            .waddr (wr_ptr_q),
            .wdata (wdata_st),
            .raddr (rd_ptr_q),
            .rdata (bank_rdata[b])
        );
    end

    // Write and read sides never target the same bank in one cycle,
    // so their flag updates are independent.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (flush) begin
            state_d[0] = FILLING;
            state_d[1] = FILLING;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (wr_fire) begin
                if (wr_ptr_q == LAST) begin
                    wr_ptr_d           = '0;
                    wr_bank_d          = !wr_bank_q;
                    state_d[wr_bank_q] = FULL;
                end else begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end
            if (rd_fire) begin
                if (rd_ptr_q == LAST) begin
                    rd_ptr_d           = '0;
                    rd_bank_d          = !rd_bank_q;
                    state_d[rd_bank_q] = FILLING;
                end else begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0] <= FILLING;
            state_q[1] <= FILLING;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_layer_result_buffer.sv
// Bench for layer_result_buffer: directed frames plus random traffic vs a frame-queue model.
// Follows LAYER_RESULT_BUFFER_BINARIZE_EN in its model of stored data.
module tb_layer_result_buffer;
    import layer_buf_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int LN = LANE_DEF;
    localparam int D  = DEPTH_DEF;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    act_vec_t      wr_data = '0;
    logic          wr_ready;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    act_vec_t      rd_data;
    logic [AW-1:0] rd_index;
    logic          rd_last;
    logic [1:0]    bank_full;

    layer_result_buffer #(.WIDTH(W), .LANE(LN), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_index  (rd_index),
        .rd_last   (rd_last),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: vectors of the frame being filled, then all complete frames in order.
    act_vec_t fill_q[$];
    act_vec_t pend[$];
    int       nfull, rd_pos, fr_r;
    logic     acc;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic act_vec_t binz(input act_vec_t v);
        act_vec_t r;
        r = v;
`ifdef LAYER_RESULT_BUFFER_BINARIZE_EN
        for (int i = 0; i < LANES; i++)
            r[i*LN +: LN] = v[i*LN + LN - 1] ? {LN{1'b1}} : {LN{1'b0}};
`endif
        return r;
    endfunction

    function automatic act_vec_t rnd_vec();
        act_vec_t r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        fill_q.delete();
        pend.delete();
        nfull  = 0;
        rd_pos = 0;
        fr_r   = 0;
    endtask

    task automatic check_all();
        logic       ev;
        logic [1:0] ef;
        ev = (nfull > 0);
        ef = (nfull == 2) ? 2'b11 : (nfull == 1) ? 2'(1 << (fr_r % 2)) : 2'b00;
        chk("wr_ready", W'(wr_ready), W'(nfull < 2));
        chk("rd_valid", W'(rd_valid), W'(ev));
        chk("rd_data", rd_data, ev ? pend[rd_pos] : '0);
        chk("rd_index", W'(rd_index), W'(rd_pos));
        chk("rd_last", W'(rd_last), W'(ev && rd_pos == D - 1));
        chk("bank_full", W'(bank_full), W'(ef));
    endtask

    task automatic model_step();
        logic wf, rf;
        wf  = wr_valid && (nfull < 2);
        rf  = rd_ready && (nfull > 0);
        acc = rst_n && !flush && wf;
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            if (rf) begin
                rd_pos++;
                if (rd_pos == D) begin
                    for (int i = 0; i < D; i++) void'(pend.pop_front());
                    rd_pos = 0;
                    nfull--;
                    fr_r++;
                end
            end
            if (wf) begin
                fill_q.push_back(binz(wr_data));
                if (fill_q.size() == D) begin
                    foreach (fill_q[i]) pend.push_back(fill_q[i]);
                    fill_q.delete();
                    nfull++;
                end
            end
        end
    endtask

    task automatic tick(input logic wv, input act_vec_t wd, input logic rr, input logic fl);
        @(negedge clk);
        check_all();
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    act_vec_t v, pat;
    int       waits;
    int       p_wr, p_rd;
    logic     cur_wv;
    act_vec_t cur_wd;

    initial begin
        model_clear();
        acc = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // One frame of 1..7 back-to-back, then drained at full rate.
        for (int i = 1; i <= D; i++) tick(1'b1, W'(i), 1'b0, 1'b0);
        for (int i = 0; i < D; i++) tick(1'b0, '0, 1'b1, 1'b0);

        // Two frames with reads stalled; a 15th write must wait for the first drain.
        for (int i = 0; i < 2 * D; i++) tick(1'b1, rnd_vec(), 1'b0, 1'b0);
        v = rnd_vec();
        for (int i = 0; i < 3; i++) tick(1'b1, v, 1'b0, 1'b0);
        chk("wr15_held", W'(acc), W'(0));
        for (int i = 0; i < D; i++) tick(1'b1, v, 1'b1, 1'b0);
        chk("wr15_before_free", W'(acc), W'(0));
        waits = 0;
        do begin
            tick(1'b1, v, 1'b0, 1'b0);
            waits++;
        end while (!acc && waits < 10);
        chk("wr15_latency", W'(waits), W'(1));
        for (int i = 0; i < D; i++) tick(1'b0, '0, 1'b1, 1'b0);

        // Random stalls during a drain.
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) tick(1'b1, rnd_vec(), 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) tick(1'b0, '0, 1'($urandom_range(1)), 1'b0);

        // Last write of frame B coincides with rd_last of frame A.
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) tick(1'b1, rnd_vec(), 1'b0, 1'b0);
        for (int i = 0; i < D; i++) tick(1'b1, rnd_vec(), 1'b1, 1'b0);
        chk("same_cycle_nfull", W'(nfull), W'(1));
        for (int i = 0; i < D; i++) tick(1'b0, '0, 1'b1, 1'b0);

        // Flush after 3 writes and 2 reads of a frame, then a fresh frame.
        for (int i = 0; i < D; i++) tick(1'b1, rnd_vec(), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b1, rnd_vec(), 1'b1, 1'b0);
        tick(1'b1, rnd_vec(), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) tick(1'b1, rnd_vec(), 1'b0, 1'b0);
        for (int i = 0; i < D; i++) tick(1'b0, '0, 1'b1, 1'b0);

        // Binarize edge lanes: 8000 / 7FFF / FFFF / 0000 repeated.
        for (int i = 0; i < LANES; i++) begin
            case (i % 4)
                0:       pat[i*LN +: LN] = 16'h8000;
                1:       pat[i*LN +: LN] = 16'h7FFF;
                2:       pat[i*LN +: LN] = 16'hFFFF;
                default: pat[i*LN +: LN] = 16'h0000;
            endcase
        end
        for (int i = 0; i < D; i++) tick(1'b1, pat, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) tick(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with rare flush and reset.
        cur_wv = 1'b0;
        cur_wd = '0;
        for (int k = 0; k < 800; k++) begin
            if (k % 100 == 0) begin
                p_wr = $urandom_range(20, 100);
                p_rd = $urandom_range(10, 100);
            end
            if (!(cur_wv && !acc)) begin
                cur_wv = ($urandom_range(99) < p_wr);
                cur_wd = rnd_vec();
            end
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                tick(cur_wv, cur_wd, 1'($urandom_range(99) < p_rd),
                     1'($urandom_range(199) == 0));
            end
        end

        @(negedge clk);
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
